// File: rtl/regfile_clr.sv
// -----------------------------------------------------------------------------
// regfile_clr
//
// Register file for the CPU datapath. It has WIDTH-bit entries, 2**AW of them,
// two combinational read ports and one synchronous write port. Register 0
// always reads as zero.
//
// The array is cleared by an IDLE/CLEAR state machine that zeroes one entry per
// clock. A clear is started by reset, or by clr_req while the machine is IDLE.
// While a clear sweep runs:
//   - busy is high,
//   - both read ports return zero,
//   - writes are dropped.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   When this macro is defined, a write that commits at the next edge is
//   forwarded to any read port addressing the same register in the same cycle.
//   The default build has no forwarding.
//
// Ports:
//   clk      in   1      rising-edge clock
//   reset    in   1      synchronous, active-high; restarts a full clear sweep
//   clr_req  in   1      single-cycle clear request, honoured only in IDLE
//   we       in   1      write enable
//   wa       in   AW     write address
//   wd       in   WIDTH  write data
//   ra_a     in   AW     read address, port A
//   ra_b     in   AW     read address, port B
//   rd_a     out  WIDTH  read data, port A (combinational)
//   rd_b     out  WIDTH  read data, port B (combinational)
//   busy     out  1      high while a clear sweep is in progress
// -----------------------------------------------------------------------------

// Property checks on the register-file outputs. Kept apart from the datapath.
module regfile_clr_checker #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input logic             clk,
    input logic             reset,
    input logic             busy,
    input logic [AW-1:0]    ra_a,
    input logic [AW-1:0]    ra_b,
    input logic [WIDTH-1:0] rd_a,
    input logic [WIDTH-1:0] rd_b
);

    a_busy_masks_reads: assert property (@(posedge clk) disable iff (reset)
        busy |-> ((rd_a == '0) && (rd_b == '0)));

    a_zero_reg_port_a: assert property (@(posedge clk) disable iff (reset)
        (ra_a == '0) |-> (rd_a == '0));

    a_zero_reg_port_b: assert property (@(posedge clk) disable iff (reset)
        (ra_b == '0) |-> (rd_b == '0));

endmodule

module regfile_clr #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_req,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra_a,
    input  logic [AW-1:0]    ra_b,
    output logic [WIDTH-1:0] rd_a,
    output logic [WIDTH-1:0] rd_b,
    output logic             busy
);

    localparam int DEPTH = 2 ** AW;

    localparam logic [AW-1:0]    ADDR_ZERO_C = '0;
    localparam logic [AW-1:0]    CNT_LAST_C  = AW'(DEPTH - 1);
    localparam logic [AW-1:0]    CNT_ONE_C   = AW'(1);
    localparam logic [WIDTH-1:0] DATA_ZERO_C = '0;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           state_r;
    logic [AW-1:0]    clr_cnt_r;
    logic             busy_r;
    logic [WIDTH-1:0] mem_r [DEPTH];

    logic             idle_s;
    logic             user_wr_s;
    logic             fwd_a_s;
    logic             fwd_b_s;
    logic             mem_we_s;
    logic [AW-1:0]    mem_wa_s;
    logic [WIDTH-1:0] mem_wd_s;
    logic [WIDTH-1:0] rd_a_s;
    logic [WIDTH-1:0] rd_b_s;

    assign idle_s = (state_r == ST_IDLE);

    // A user write commits only in IDLE, and only to a nonzero address.
    // A same-cycle reset or clear request drops the write. That write would be
    // wiped by the sweep anyway, so dropping it keeps forwarding consistent with
    // what is actually stored.
    assign user_wr_s = idle_s && !reset && !clr_req && we && (wa != ADDR_ZERO_C);

`ifdef REGFILE_BYPASS_EN
    assign fwd_a_s = user_wr_s && (ra_a == wa);
    assign fwd_b_s = user_wr_s && (ra_b == wa);
`else
    assign fwd_a_s = 1'b0;
    assign fwd_b_s = 1'b0;
`endif

    // Sweep control.
    // busy is registered. It is the state register's CLEAR flag computed one
    // edge early, so it is high exactly while the machine is in CLEAR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= ADDR_ZERO_C;
            busy_r    <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_r   <= ST_CLEAR;
                        clr_cnt_r <= ADDR_ZERO_C;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        clr_cnt_r <= ADDR_ZERO_C;
                        busy_r    <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_r == CNT_LAST_C) begin
                        state_r   <= ST_IDLE;
                        clr_cnt_r <= ADDR_ZERO_C;
                        busy_r    <= 1'b0;
                    end else begin
                        state_r   <= ST_CLEAR;
                        clr_cnt_r <= clr_cnt_r + CNT_ONE_C;
                        busy_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_cnt_r <= ADDR_ZERO_C;
                    busy_r    <= 1'b1;
                end
            endcase
        end
    end

    // Single array write port, shared between the sweep and user writes.
    // Entry 0 is never stored because reads of address 0 are masked to zero.
    always_comb begin
        mem_we_s = 1'b0;
        mem_wa_s = ADDR_ZERO_C;
        mem_wd_s = DATA_ZERO_C;
        if (state_r == ST_CLEAR) begin
            mem_we_s = (clr_cnt_r != ADDR_ZERO_C);
            mem_wa_s = clr_cnt_r;
            mem_wd_s = DATA_ZERO_C;
        end else if (user_wr_s) begin
            mem_we_s = 1'b1;
            mem_wa_s = wa;
            mem_wd_s = wd;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array. It has no reset; the clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_wa_s] <= mem_wd_s;
        end
    end

    // Read port A.
    always_comb begin
        rd_a_s = DATA_ZERO_C;
        if (state_r == ST_CLEAR) begin
            rd_a_s = DATA_ZERO_C;
        end else if (ra_a == ADDR_ZERO_C) begin
            rd_a_s = DATA_ZERO_C;
        end else if (fwd_a_s) begin
            rd_a_s = wd;
        end else begin
            rd_a_s = mem_r[ra_a];
        end
    end

    // Read port B. It is independent of port A and may read the same address.
    always_comb begin
        rd_b_s = DATA_ZERO_C;
        if (state_r == ST_CLEAR) begin
            rd_b_s = DATA_ZERO_C;
        end else if (ra_b == ADDR_ZERO_C) begin
            rd_b_s = DATA_ZERO_C;
        end else if (fwd_b_s) begin
            rd_b_s = wd;
        end else begin
            rd_b_s = mem_r[ra_b];
        end
    end

    assign rd_a = rd_a_s;
    assign rd_b = rd_b_s;
    assign busy = busy_r;

    regfile_clr_checker #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_checker (
        .clk   (clk),
        .reset (reset),
        .busy  (busy),
        .ra_a  (ra_a),
        .ra_b  (ra_b),
        .rd_a  (rd_a),
        .rd_b  (rd_b)
    );

endmodule
